// File: rtl/array_sequencer_pkg.sv
// Shared types and default sizes for the systolic array sequencer.
package seq_pkg;
  localparam int WORD_W    = 64;
  localparam int ARRAY_DIM = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    IDLE, LOAD_W, START, STREAM, DRAIN, DONE
  } seq_state_t;
endpackage

// File: rtl/array_sequencer_if.sv
// SRAM-controller side of the sequencer: source word stream in, result rows out.
interface array_sequencer_if #(parameter int WORD_W = 64);
  logic [WORD_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic [WORD_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (output src_data, src_valid, res_ready,
                  input  src_ready, res_data, res_valid);
  modport slave  (input  src_data, src_valid, res_ready,
                  output src_ready, res_data, res_valid);
endinterface

// File: rtl/array_sequencer_result_fifo.sv
// Small synchronous FIFO for activation rows; head is read combinationally.
module result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wp_q, rp_q;
  logic [CW-1:0]           cnt_q;
  logic                    do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/array_sequencer.sv
// Sequences weight load and credit-controlled input streaming into the
// systolic array, collecting returned activation rows into a result FIFO.
module array_sequencer #(
  parameter int ARRAY_DIM  = 8,
  parameter int WORD_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_load_weight,
  input  logic              cmd_start,
  input  logic [7:0]        num_inputs,
  input  logic [2:0]        act_mode_cfg,
  input  logic [WORD_W-1:0] bias_cfg,
  array_sequencer_if.slave  sram,
  output logic              load,
  output logic              array_in_valid,
  output logic [WORD_W-1:0] inputs,
  output logic [WORD_W-1:0] bias,
  output logic [2:0]        activation_mode,
  output logic              array_start,
  input  logic              array_busy,
  input  logic [WORD_W-1:0] activations,
  input  logic              activations_valid,
  output logic              seq_busy,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);
  import seq_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t        state_q;
  logic              weights_loaded_q;
  logic [CNT_W-1:0]  wcnt_q, icnt_q, rcnt_q, num_q;
  logic [CW-1:0]     in_flight_q;
  logic              load_q, ivld_q, start_q, done_q, err_q;
  logic [WORD_W-1:0] inputs_q, bias_q;
  logic [2:0]        mode_q;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              capture_st, cap, push, pop, src_rdy, src_hs, credit_ok, err_set;

  assign capture_st = (state_q == STREAM) || (state_q == DRAIN);
  assign cap        = capture_st && activations_valid;
  assign push       = cap && !fifo_full;
  assign pop        = sram.res_ready && !fifo_empty;
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, in_flight_q}) < (CW+1)'(FIFO_DEPTH);
  assign src_hs     = sram.src_valid && src_rdy;

  always_comb begin
    src_rdy = 1'b0;
    case (state_q)
      LOAD_W:  src_rdy = 1'b1;
      STREAM:  src_rdy = (icnt_q < num_q) && credit_ok;
      default: src_rdy = 1'b0;
    endcase
  end

  always_comb begin
    err_set = activations_valid && (!capture_st || fifo_full);
    if (cmd_load_weight || cmd_start) begin
      if (state_q != IDLE)
        err_set = 1'b1;
      else if (!cmd_load_weight && (!weights_loaded_q || num_inputs == '0))
        err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q          <= IDLE;
      weights_loaded_q <= 1'b0;
      wcnt_q           <= '0;
      icnt_q           <= '0;
      rcnt_q           <= '0;
      num_q            <= '0;
      in_flight_q      <= '0;
      load_q           <= 1'b0;
      ivld_q           <= 1'b0;
      start_q          <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      inputs_q         <= '0;
      bias_q           <= '0;
      mode_q           <= '0;
    end else begin
      load_q  <= src_hs && (state_q == LOAD_W);
      ivld_q  <= src_hs && (state_q == STREAM);
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= err_set | (err_q & ~err_clr);
      if (src_hs) inputs_q <= sram.src_data;

      // Rows dropped on a full FIFO are still counted so the job terminates.
      if (capture_st) begin
        if (src_hs) icnt_q <= icnt_q + 1'b1;
        if (cap)    rcnt_q <= rcnt_q + 1'b1;
        if (src_hs && !cap)
          in_flight_q <= in_flight_q + 1'b1;
        else if (!src_hs && cap && in_flight_q != '0)
          in_flight_q <= in_flight_q - 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cmd_load_weight) begin
            state_q <= LOAD_W;
            wcnt_q  <= '0;
          end else if (cmd_start && weights_loaded_q && num_inputs != '0) begin
            state_q <= START;
            start_q <= 1'b1;
            num_q   <= num_inputs;
            bias_q  <= bias_cfg;
            mode_q  <= act_mode_cfg;
          end
        end
        LOAD_W: begin
          if (src_hs) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q == CNT_W'(ARRAY_DIM - 1)) begin
              weights_loaded_q <= 1'b1;
              state_q          <= IDLE;
            end
          end
        end
        START: begin
          icnt_q      <= '0;
          rcnt_q      <= '0;
          in_flight_q <= '0;
          state_q     <= STREAM;
        end
        STREAM:  if (icnt_q == num_q) state_q <= DRAIN;
        DRAIN: begin
          if (rcnt_q == num_q && !array_busy) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  result_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (push),
    .din_i   (activations),
    .pop_i   (pop),
    .dout_o  (sram.res_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign sram.src_ready  = src_rdy;
  assign sram.res_valid  = !fifo_empty;
  assign load            = load_q;
  assign array_in_valid  = ivld_q;
  assign inputs          = inputs_q;
  assign bias            = bias_q;
  assign activation_mode = mode_q;
  assign array_start     = start_q;
  assign seq_busy        = (state_q != IDLE);
  assign done            = done_q;
  assign err             = err_q;
endmodule

// File: tb/tb_array_sequencer.sv
// Directed bench: per-cycle vector table for command/load behaviour, then
// scripted inference, backpressure and mid-job reset sequences.
module tb_array_sequencer;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_load_weight, cmd_start, array_busy, activations_valid, err_clr;
  logic [7:0]  num_inputs;
  logic [2:0]  act_mode_cfg;
  logic [63:0] bias_cfg, activations;
  logic        load, array_in_valid, array_start, seq_busy, done, err;
  logic [63:0] inputs, bias;
  logic [2:0]  activation_mode;

  array_sequencer_if #(.WORD_W(64)) sif ();

  array_sequencer #(.ARRAY_DIM(8), .WORD_W(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_load_weight(cmd_load_weight), .cmd_start(cmd_start),
    .num_inputs(num_inputs), .act_mode_cfg(act_mode_cfg), .bias_cfg(bias_cfg), .sram(sif),
    .load(load), .array_in_valid(array_in_valid), .inputs(inputs), .bias(bias),
    .activation_mode(activation_mode), .array_start(array_start), .array_busy(array_busy),
    .activations(activations), .activations_valid(activations_valid), .seq_busy(seq_busy),
    .done(done), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic cl, cs; logic [7:0] num; logic sv; logic [63:0] sd; logic av, ec;
    logic e_rdy, e_load; logic [63:0] e_in; logic e_busy, e_err, e_rv, e_st;
  } vec_t;
  vec_t vq[$];

  task automatic addv(input logic cl, cs, input logic [7:0] num, input logic sv,
                      input logic [63:0] sd, input logic av, ec, e_rdy, e_load,
                      input logic [63:0] e_in, input logic e_busy, e_err, e_rv, e_st);
    vec_t v;
    v.cl = cl; v.cs = cs; v.num = num; v.sv = sv; v.sd = sd; v.av = av; v.ec = ec;
    v.e_rdy = e_rdy; v.e_load = e_load; v.e_in = e_in; v.e_busy = e_busy;
    v.e_err = e_err; v.e_rv = e_rv; v.e_st = e_st;
    vq.push_back(v);
  endtask

  // Array model state: results return two cycles after each issued row.
  int          cyc = 0, job_n = 0, ret_idx = 0, exp_idx = 0;
  int          start_cnt = 0, done_cnt = 0, iv_cnt = 0;
  int          issue_q[$];
  logic [63:0] sent_q[$];

  task automatic clear_job(input int n);
    job_n = n; ret_idx = 0; exp_idx = 0; start_cnt = 0; done_cnt = 0; iv_cnt = 0;
    issue_q.delete(); sent_q.delete();
  endtask

  task automatic tick();
    logic hs;
    logic [63:0] sent;
    if (sif.res_valid && sif.res_ready) begin
      chk("res_data", sif.res_data, 64'((exp_idx + 1) * 16));
      exp_idx++;
    end
    hs = sif.src_valid && sif.src_ready;
    if (hs) sent_q.push_back(sif.src_data);
    @(posedge clk); #1;
    cyc++;
    if (hs) sif.src_data = sif.src_data + 64'd1;
    if (array_start) begin start_cnt++; array_busy = 1'b1; end
    if (done) done_cnt++;
    chk("strobe_excl", 64'(int'(load) + int'(array_in_valid) + int'(array_start) <= 1), 64'd1);
    if (array_in_valid) begin
      iv_cnt++;
      sent = (sent_q.size() > 0) ? sent_q.pop_front() : 64'hDEAD;
      chk("inputs_row", inputs, sent);
      issue_q.push_back(cyc + 2);
    end
    activations_valid = 1'b0;
    if (issue_q.size() > 0 && issue_q[0] <= cyc) begin
      void'(issue_q.pop_front());
      activations       = 64'((ret_idx + 1) * 16);
      activations_valid = 1'b1;
      ret_idx++;
    end
    if (ret_idx == job_n && array_busy && issue_q.size() == 0 && !activations_valid)
      array_busy = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; cmd_load_weight = 0; cmd_start = 0; num_inputs = 0; act_mode_cfg = 0;
    bias_cfg = 0; array_busy = 0; activations = 0; activations_valid = 0; err_clr = 0;
    sif.src_data = 0; sif.src_valid = 0; sif.res_ready = 0;

    addv(0,1,3,0,0,0,0, 0,0,0,0,1,0,0);                  // start before any weights
    addv(0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
    addv(1,0,0,0,0,0,0, 0,0,0,1,0,0,0);
    for (int k = 1; k <= 8; k++) addv(0,0,0,1,64'(k),0,0, 1,1,64'(k),k<8,0,0,0);
    addv(0,0,0,0,0,0,0, 0,0,8,0,0,0,0);                  // inputs holds last word
    addv(0,0,0,0,0,1,0, 0,0,8,0,1,0,0);                  // stray row in IDLE
    addv(0,0,0,0,0,0,1, 0,0,8,0,0,0,0);
    addv(1,1,3,0,0,0,0, 0,0,8,1,0,0,0);                  // load beats start
    for (int k = 'h11; k <= 'h18; k++) addv(0,0,0,1,64'(k),0,0, 1,1,64'(k),k<'h18,0,0,0);
    addv(0,1,0,0,0,0,0, 0,0,'h18,0,1,0,0);              // num_inputs == 0
    addv(0,0,0,0,0,0,1, 0,0,'h18,0,0,0,0);
    addv(1,0,0,0,0,0,0, 0,0,'h18,1,0,0,0);
    addv(0,1,3,0,0,0,0, 1,0,'h18,1,1,0,0);              // command while busy
    for (int k = 'h21; k <= 'h28; k++)
      addv(0,0,0,1,64'(k),0,k=='h21, 1,1,64'(k),k<'h28,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", load, 0);         chk("rst_seq_busy", seq_busy, 0);
    chk("rst_err", err, 0);           chk("rst_res_valid", sif.res_valid, 0);
    chk("rst_inputs", inputs, 0);     chk("rst_src_ready", sif.src_ready, 0);
    n_rst = 1'b1;

    foreach (vq[i]) begin
      cmd_load_weight = vq[i].cl; cmd_start = vq[i].cs; num_inputs = vq[i].num;
      sif.src_valid = vq[i].sv; sif.src_data = vq[i].sd;
      activations_valid = vq[i].av; err_clr = vq[i].ec;
      #1;
      chk($sformatf("v%0d_src_ready", i), sif.src_ready, vq[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_load", i), load, vq[i].e_load);
      chk($sformatf("v%0d_inputs", i), inputs, vq[i].e_in);
      chk($sformatf("v%0d_busy", i), seq_busy, vq[i].e_busy);
      chk($sformatf("v%0d_err", i), err, vq[i].e_err);
      chk($sformatf("v%0d_res_valid", i), sif.res_valid, vq[i].e_rv);
      chk($sformatf("v%0d_start", i), array_start, vq[i].e_st);
    end
    cmd_load_weight = 0; cmd_start = 0; sif.src_valid = 0; activations_valid = 0; err_clr = 0;

    // Full inference, 3 rows
    clear_job(3);
    sif.res_ready = 1'b1; sif.src_valid = 1'b1; sif.src_data = 64'h100;
    num_inputs = 3; bias_cfg = 64'hAA; act_mode_cfg = 3'd2; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    sif.src_valid = 1'b0;
    repeat (4) tick();
    chk("inf_done", done_cnt, 1);       chk("inf_start", start_cnt, 1);
    chk("inf_rows", iv_cnt, 3);         chk("inf_results", exp_idx, 3);
    chk("inf_bias", bias, 64'hAA);      chk("inf_mode", activation_mode, 2);
    chk("inf_err", err, 0);             chk("inf_busy", seq_busy, 0);

    // Backpressure, 6 rows with the consumer stalled
    clear_job(6);
    sif.res_ready = 1'b0; sif.src_valid = 1'b1; sif.src_data = 64'h200;
    num_inputs = 6; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (30) tick();
    chk("bp_rows_stalled", iv_cnt, 4);  chk("bp_src_ready", sif.src_ready, 0);
    chk("bp_res_valid", sif.res_valid, 1);
    sif.res_ready = 1'b1;
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    sif.src_valid = 1'b0;
    repeat (6) tick();
    chk("bp_done", done_cnt, 1);        chk("bp_rows", iv_cnt, 6);
    chk("bp_results", exp_idx, 6);      chk("bp_err", err, 0);

    // Reset after two of five rows
    clear_job(5);
    sif.src_valid = 1'b1; sif.src_data = 64'h300; num_inputs = 5; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    for (int i = 0; i < 50 && iv_cnt < 2; i++) tick();
    chk("mid_rows", iv_cnt, 2);
    n_rst = 1'b0; sif.src_valid = 1'b0; activations_valid = 1'b0; array_busy = 1'b0;
    issue_q.delete();
    @(posedge clk); #1;
    chk("mr_load", load, 0);            chk("mr_aiv", array_in_valid, 0);
    chk("mr_inputs", inputs, 0);        chk("mr_bias", bias, 0);
    chk("mr_mode", activation_mode, 0); chk("mr_start", array_start, 0);
    chk("mr_src_ready", sif.src_ready, 0); chk("mr_res_valid", sif.res_valid, 0);
    chk("mr_res_data", sif.res_data, 0);   chk("mr_busy", seq_busy, 0);
    chk("mr_done", done, 0);            chk("mr_err", err, 0);
    n_rst = 1'b1; num_inputs = 3; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    chk("mr_nowt_err", err, 1);         chk("mr_nowt_busy", seq_busy, 0);
    chk("mr_nowt_start", array_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/array_sequencer.md
Name: array_sequencer

Overview:
Sequences the systolic array for one inference job. It loads ARRAY_DIM weight rows, then streams num_inputs input rows into the array under credit-based flow control. Activation rows returned by the array are collected into a small result FIFO that the SRAM controller drains. The block sits between the SRAM controller and the systolic array, and its outputs replace direct AHB-side driving of load, start and inputs.

Parameters:
ARRAY_DIM, 8, weight rows per load (array height)
WORD_W, 64, data word width (8 lanes x int8)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
n_rst  in  1  synchronous active-low reset
cmd_load_weight  in  1  pulse: begin weight load
cmd_start  in  1  pulse: begin inference
num_inputs  in  8  input rows per inference; sampled on accepted cmd_start
act_mode_cfg  in  3  activation mode; sampled on accepted cmd_start
bias_cfg  in  WORD_W  bias word; sampled on accepted cmd_start
src_data  in  WORD_W  weight/input word from SRAM side
src_valid  in  1  src_data valid
src_ready  out  1  sequencer accepts src_data this cycle
load  out  1  array weight-load strobe
array_in_valid  out  1  array input-row strobe
inputs  out  WORD_W  word to array
bias  out  WORD_W  latched bias
activation_mode  out  3  latched mode
array_start  out  1  one-cycle start pulse
array_busy  in  1  array computing
activations  in  WORD_W  result row
activations_valid  in  1  result row valid
res_data  out  WORD_W  FIFO head
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer pops head
seq_busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
err  out  1  sticky error
err_clr  in  1  clears err

Behaviour:
- Reset: all outputs 0. State is IDLE, weights_loaded=0, FIFO empty, all counters 0. Reset mid-operation aborts the job immediately. No done pulse is generated.
- States: IDLE, LOAD_W, START, STREAM, DRAIN, DONE.
- IDLE:
  - cmd_load_weight -> LOAD_W; wcnt=0.
  - cmd_start -> START, provided weights_loaded=1 and num_inputs!=0. Otherwise set err and stay in IDLE.
  - Both commands in the same cycle: load wins, start is dropped, no err.
- LOAD_W:
  - src_ready=1.
  - On each handshake, next cycle: load=1, inputs=src_data, wcnt++ (1-cycle registered latency).
  - After the ARRAY_DIM-th handshake: weights_loaded=1 -> IDLE.
- START:
  - bias, activation_mode and num_inputs are already latched at cmd_start acceptance.
  - array_start=1 for exactly this cycle.
  - icnt=0, rcnt=0, in_flight=0 -> STREAM.
- STREAM:
  - src_ready = (icnt<num_inputs) && (fifo_count+in_flight < FIFO_DEPTH).
  - On each handshake, next cycle: array_in_valid=1, inputs=src_data; icnt++, in_flight++.
  - When icnt==num_inputs -> DRAIN.
- Result capture (STREAM/DRAIN):
  - activations_valid pushes activations into the FIFO, rcnt++, in_flight--.
  - An input issue and a result capture in the same cycle leave in_flight net unchanged.
  - FIFO push and pop in the same cycle are both performed; count unchanged.
- DRAIN: rcnt==num_inputs && !array_busy -> DONE.
- DONE: done=1 for one cycle -> IDLE. FIFO contents persist until popped.
- Errors (set err, never stall):
  - Command while seq_busy: command ignored.
  - activations_valid in IDLE/LOAD_W/START/DONE: row dropped.
  - activations_valid with FIFO full: row dropped.
  - err_clr clears err. A simultaneous set wins.
- load, array_in_valid and array_start are mutually exclusive.
- inputs holds its last value when no strobe is active.
- Widths:
  - icnt and rcnt are 8-bit.
  - in_flight and fifo_count are $clog2(FIFO_DEPTH)+1 bits.
  - No counter wraps, because termination compares against num_inputs.

Decomposition:
- Package seq_pkg:
  - seq_state_t enum (IDLE, LOAD_W, START, STREAM, DRAIN, DONE).
  - WORD_W and ARRAY_DIM localparam defaults.
  - CNT_W=8.
- Sub-module result_fifo:
  - Synchronous FIFO with push/pop/full/empty/count.
  - Same clk and n_rst; reset is synchronous active-low.
  - Head appears on res_data combinationally from the read pointer.

Test Plan:
- Weight load: cmd_load_weight, 8 words 0x01..0x08 back-to-back -> load high 8 cycles, each one cycle after its handshake, inputs=0x01..0x08; then IDLE, seq_busy=0.
- Start without weights after reset: cmd_start -> err=1, array_start never asserts; err_clr -> err=0.
- Full inference, num_inputs=3, bias=0xAA, mode=2: array_start pulses once; 3 array_in_valid strobes; model returns 3 rows 0x10,0x20,0x30 with res_ready=1 -> res_data in that order, done pulses once after array_busy falls.
- Backpressure, num_inputs=6, res_ready=0: src_ready drops after 4 issued rows (FIFO_DEPTH=4). Raise res_ready -> remaining 2 rows issue, all 6 results delivered, err=0.
- Collision/stray: cmd_load_weight and cmd_start together -> LOAD_W only, err=0. activations_valid in IDLE -> err=1, FIFO still empty.
- Reset mid-STREAM after 2 of 5 rows -> next cycle all outputs 0, FIFO empty, weights_loaded=0 (a subsequent cmd_start sets err).
